// File: rtl/fp32_unary_stream_adapter.sv
`timescale 1ns/1ps
// fp32_unary_stream_adapter
// Valid/ready streaming shell around a fixed-latency, non-stallable FP32 unary
// core (e.g. fp32_sqrt). Each accepted operand is registered onto core_a.
// A one-bit tag travels alongside it through a shift register. When the tag
// reaches the end of that register, the core result is written into a
// first-word-fall-through output FIFO. Admission is credit based, so the FIFO
// can never overflow: the occupancy counter covers operands still in the core
// plus results waiting in the FIFO.
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   in_valid     operand valid
//   in_ready     adapter can accept an operand this cycle (registered state only)
//   in_data      FP32 operand
//   out_valid    out_data holds a result
//   out_ready    consumer takes the result this cycle
//   out_data     FP32 result, in operand order
//   core_a       operand to the core (registered, zero when idle)
//   core_result  result from the core, LATENCY cycles after core_a
//   occupancy    accepted operands not yet popped (in flight + queued)
//   busy         occupancy != 0

module fp32_unary_stream_adapter #(
   parameter int LATENCY    = 26,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [31:0]                       in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [31:0]                       out_data,
   output logic [31:0]                       core_a,
   input  logic [31:0]                       core_result,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy,
   output logic                              busy
);

   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

   logic [LATENCY:0]  tag;
   logic [PTR_W:0]    wr_ptr;
   logic [PTR_W:0]    rd_ptr;
   logic [31:0]       mem [FIFO_DEPTH];

   logic accept;
   logic pop;
   logic push;
   logic fifo_empty;
   logic fifo_full;

   // Credit check uses only registered occupancy, so a pop frees its slot one
   // cycle later and there is no combinational path from out_ready to in_ready.
   assign in_ready   = (occupancy < DEPTH_OCC);
   assign accept     = in_valid & in_ready;

   // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign out_valid  = !fifo_empty;
   assign out_data   = mem[rd_ptr[PTR_W-1:0]];
   assign pop        = out_valid & out_ready;
   assign push       = tag[LATENCY];
   assign busy       = (occupancy != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occupancy <= '0;
         tag       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         core_a    <= '0;
      end else begin
         // Idle cycles feed +0.0 so the core never sees a stale or odd operand.
         core_a <= accept ? in_data : 32'h0;
         tag    <= {tag[LATENCY-1:0], accept};

         if (accept && !pop) begin
            occupancy <= occupancy + OCC_W'(1);
         end else if (pop && !accept) begin
            occupancy <= occupancy - OCC_W'(1);
         end

         if (push) begin
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

   // Storage needs no reset: contents are only visible between valid pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[PTR_W-1:0]] <= core_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(push && fifo_full));
         assert (!(pop && fifo_empty));
         assert (occupancy <= DEPTH_OCC);
      end
   end

endmodule

// File: tb/tb_fp32_unary_stream_adapter.sv
`timescale 1ns/1ps
// Directed and random bench for fp32_unary_stream_adapter with a LATENCY-deep
// behavioural core and a result scoreboard.
module tb_fp32_unary_stream_adapter;

   localparam int LATENCY    = 26;
   localparam int FIFO_DEPTH = 32;
   localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_data;
   logic [31:0]       core_a;
   logic [31:0]       core_result;
   logic [OCC_W-1:0]  occupancy;
   logic              busy;

   always #5 clk = ~clk;

   fp32_unary_stream_adapter #(
      .LATENCY    (LATENCY),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .core_a      (core_a),
      .core_result (core_result),
      .occupancy   (occupancy),
      .busy        (busy)
   );

   // Behavioural core: exact sqrt for the directed values, an arbitrary but
   // fixed bijection elsewhere so ordering errors show up in the data.
   function automatic logic [31:0] core_f(input logic [31:0] x);
      case (x)
         32'h4080_0000: core_f = 32'h4000_0000;
         32'h4110_0000: core_f = 32'h4040_0000;
         32'h4180_0000: core_f = 32'h4080_0000;
         32'h3F80_0000: core_f = 32'h3F80_0000;
         32'h0000_0000: core_f = 32'h0000_0000;
         32'h7F80_0000: core_f = 32'h7F80_0000;
         32'hBF80_0000: core_f = 32'h7FC0_0000;
         default:       core_f = x ^ 32'h5A5A_A5A5;
      endcase
   endfunction

   logic [31:0] cpipe [LATENCY];
   always @(posedge clk) begin
      cpipe[0] <= core_f(core_a);
      for (int i = 1; i < LATENCY; i++) cpipe[i] <= cpipe[i-1];
   end
   assign core_result = cpipe[LATENCY-1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: expected results in acceptance order. Its length is by
   // definition the number of accepted-but-unpopped operands.
   logic [31:0] sb [$];
   int acc_cnt = 0;
   int pop_cnt = 0;
   bit mon_en  = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (!rst_n) begin
            sb.delete();
         end else begin
            chk("occupancy", 32'(occupancy), 32'(sb.size()));
            if (in_valid && in_ready) begin
               sb.push_back(core_f(in_data));
               acc_cnt++;
            end
            if (out_valid && out_ready) begin
               pop_cnt++;
               chk("pop_model_nonempty", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) chk("out_data_order", out_data, sb.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, stall, vcnt, gaps, acc0, pop0, stale, guard;

      rst_n = 1'b0;
      repeat (3) step();
      mon_en = 1'b1;
      rst_n  = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_core_a", core_a, 32'h0);

      // single op, latency
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h4080_0000;
      step();
      chk("t1_core_a", core_a, 32'h4080_0000);
      in_valid = 1'b0;
      in_data  = '0;
      lat = 0;
      while (lat < 100 && !out_valid) begin
         step();
         lat++;
      end
      chk("t1_latency", lat, 27);
      chk("t1_data", out_data, 32'h4000_0000);
      step();
      chk("t1_core_a_idle", core_a, 32'h0);
      chk("t1_occ_after", 32'(occupancy), 32'd0);

      // streaming 200 ops
      acc0 = acc_cnt; pop0 = pop_cnt;
      stall = 0; vcnt = 0; gaps = 0;
      for (int c = 0; c < 300; c++) begin
         in_valid = (c < 200);
         in_data  = 32'h3F80_0000 + 32'(c * 4096);
         if (c < 200 && !in_ready) stall++;
         if (out_valid) vcnt++;
         else if (vcnt > 0 && vcnt < 200) gaps++;
         step();
      end
      in_valid = 1'b0;
      chk("t2_stalls", stall, 0);
      chk("t2_valid_cycles", vcnt, 200);
      chk("t2_gaps", gaps, 0);
      chk("t2_accepts", acc_cnt - acc0, 200);
      chk("t2_pops", pop_cnt - pop0, 200);

      // backpressure to full
      acc0 = acc_cnt; pop0 = pop_cnt;
      out_ready = 1'b0;
      for (int c = 0; c < 65; c++) begin
         in_valid = 1'b1;
         in_data  = 32'h4000_0000 + 32'(c);
         step();
      end
      chk("t3_accepts", acc_cnt - acc0, 32);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_occupancy", 32'(occupancy), 32'd32);
      chk("t3_out_valid", 32'(out_valid), 32'd1);

      // at occupancy 32 a pop does not admit a new operand in the same cycle
      out_ready = 1'b1;
      chk("t4_ready_at_full", 32'(in_ready), 32'd0);
      step();
      chk("t4_occ_pop_only", 32'(occupancy), 32'd31);
      chk("t4_ready_after_pop", 32'(in_ready), 32'd1);
      in_data = 32'h4180_0000;
      step();
      chk("t4_occ_accept_pop", 32'(occupancy), 32'd31);
      in_valid = 1'b0;
      guard = 0;
      while (occupancy != 0 && guard < 200) begin
         step();
         guard++;
      end
      chk("t3_drain_occ", 32'(occupancy), 32'd0);
      chk("t3_pops", pop_cnt - pop0, 33);
      chk("t3_accepts_total", acc_cnt - acc0, 33);

      // accept + pop at occupancy 1
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h3F80_0000;
      step();
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 100) begin
         step();
         guard++;
      end
      chk("t4b_out_valid", 32'(out_valid), 32'd1);
      chk("t4b_occ1", 32'(occupancy), 32'd1);
      in_valid  = 1'b1;
      in_data   = 32'h4080_0000;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t4b_occ_unchanged", 32'(occupancy), 32'd1);
      guard = 0;
      while (occupancy != 0 && guard < 100) begin
         step();
         guard++;
      end
      chk("t4b_drain", 32'(occupancy), 32'd0);

      // reset mid-stream
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = 32'h4180_0000 + 32'(c);
         step();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_occupancy", 32'(occupancy), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_core_a", core_a, 32'h0);
      stale = 0;
      repeat (40) begin
         if (out_valid) stale++;
         step();
      end
      chk("t5_stale", stale, 0);
      in_valid = 1'b1;
      in_data  = 32'h4110_0000;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (lat < 100 && !out_valid) begin
         step();
         lat++;
      end
      chk("t5_latency", lat, 27);
      chk("t5_data", out_data, 32'h4040_0000);
      step();

      // random traffic
      acc0 = acc_cnt;
      guard = 0;
      while ((acc_cnt - acc0) < 10000 && guard < 60000) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 3);
         case ($urandom_range(0, 7))
            0:       in_data = 32'hBF80_0000;
            1:       in_data = 32'h7F80_0000;
            2:       in_data = 32'h0000_0000;
            default: in_data = $urandom();
         endcase
         step();
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("t6_accepts", 32'((acc_cnt - acc0) >= 10000), 32'd1);
      guard = 0;
      while (occupancy != 0 && guard < 200) begin
         step();
         guard++;
      end
      chk("t6_drain_occ", 32'(occupancy), 32'd0);
      chk("t6_sb_empty", 32'(sb.size()), 32'd0);
      chk("t6_out_valid", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
